// File: rtl/complex_mem_port_pkg.sv
// complex_mem_port_pkg: shared widths, FSM states and the ALU memory-access opcode.
package complex_mem_port_pkg;
   localparam int NUMBER_SIZE = 8;
   localparam int ADDR_SIZE = 2 * NUMBER_SIZE;
   localparam logic [3:0] OP_MEM = 4'b1111;
   typedef enum logic [1:0] {IDLE, BEAT_RE, BEAT_IM, FINISH} state_t;
endpackage

// File: rtl/complex_mem_port_if.sv
// complex_mem_port_if: byte-wide req/ack memory bus between the load/store engine and memory.
interface complex_mem_port_if;
   import complex_mem_port_pkg::*;
   logic                   req;
   logic                   we;
   logic [ADDR_SIZE-1:0]   addr;
   logic [NUMBER_SIZE-1:0] wdata;
   logic [NUMBER_SIZE-1:0] rdata;
   logic                   ack;
   modport master(output req, we, addr, wdata, input rdata, ack);
   modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/complex_mem_port_mem_watchdog.sv
// mem_watchdog: counts stalled beat cycles; expired flags the cycle that would reach TIMEOUT.
module mem_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_enable) r_cnt <= r_cnt + 1'b1;
   end
   assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/complex_mem_port.sv
// complex_mem_port: moves one complex word (re, im bytes) to/from byte memory as two req/ack beats.
module complex_mem_port
   import complex_mem_port_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   we,
   input  logic [ADDR_SIZE-1:0]   addr,
   input  logic [NUMBER_SIZE-1:0] wdata_re,
   input  logic [NUMBER_SIZE-1:0] wdata_im,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [NUMBER_SIZE-1:0] rdata_re,
   output logic [NUMBER_SIZE-1:0] rdata_im,
   complex_mem_port_if.master     mem
);
   state_t                 r_state, w_state_n;
   logic                   r_we, r_busy, r_done, r_err, r_mem_req, r_mem_we;
   logic [ADDR_SIZE-1:0]   r_addr, r_mem_addr, w_addr_c, w_maddr_n;
   logic [NUMBER_SIZE-1:0] r_wdata_re, r_wdata_im, r_hold_re, r_rdata_re, r_rdata_im, r_mem_wdata;
   logic [NUMBER_SIZE-1:0] w_re_c, w_im_c, w_mwdata_n;
   logic                   w_accept, w_ack, w_expired, w_err_n, w_req_n, w_we_c;
   assign w_accept = (r_state == IDLE) && start && !r_busy;
   assign w_ack    = mem.ack && r_mem_req;
   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk(clk), .rst(rst),
      .i_clear(w_accept || w_ack || w_expired),
      .i_enable(r_mem_req && !mem.ack),
      .o_expired(w_expired)
   );
   always_comb begin
      w_state_n = r_state;
      w_err_n = 1'b0;
      case (r_state)
         IDLE: w_state_n = w_accept ? BEAT_RE : IDLE;
         BEAT_RE: begin
            w_state_n = w_ack ? BEAT_IM : w_expired ? IDLE : BEAT_RE;
            w_err_n = !w_ack && w_expired;
         end
         BEAT_IM: begin
            w_state_n = w_ack ? FINISH : w_expired ? IDLE : BEAT_IM;
            w_err_n = !w_ack && w_expired;
         end
         default: w_state_n = IDLE;
      endcase
   end
   // The beat about to start may use the command being accepted in this same edge.
   assign w_we_c     = w_accept ? we : r_we;
   assign w_addr_c   = w_accept ? addr : r_addr;
   assign w_re_c     = w_accept ? wdata_re : r_wdata_re;
   assign w_im_c     = w_accept ? wdata_im : r_wdata_im;
   assign w_req_n    = (w_state_n == BEAT_RE) || (w_state_n == BEAT_IM);
   assign w_maddr_n  = (w_state_n == BEAT_RE) ? w_addr_c : (w_state_n == BEAT_IM) ? w_addr_c + 1'b1 : '0;
   assign w_mwdata_n = (w_state_n == BEAT_RE) ? w_re_c : (w_state_n == BEAT_IM) ? w_im_c : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_we <= 1'b0;
         r_addr <= '0;
         r_wdata_re <= '0;
         r_wdata_im <= '0;
         r_hold_re <= '0;
         r_rdata_re <= '0;
         r_rdata_im <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err <= 1'b0;
         r_mem_req <= 1'b0;
         r_mem_we <= 1'b0;
         r_mem_addr <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_accept) begin
            r_we <= we;
            r_addr <= addr;
            r_wdata_re <= wdata_re;
            r_wdata_im <= wdata_im;
         end
         if (r_state == BEAT_RE && w_ack && !r_we) r_hold_re <= mem.rdata;
         if (r_state == BEAT_IM && w_ack && !r_we) begin
            r_rdata_re <= r_hold_re;
            r_rdata_im <= mem.rdata;
         end
         r_busy <= (w_state_n != IDLE) || w_err_n;
         r_done <= w_state_n == FINISH;
         r_err <= w_err_n;
         r_mem_req <= w_req_n;
         r_mem_we <= w_req_n && w_we_c;
         r_mem_addr <= w_maddr_n;
         r_mem_wdata <= w_mwdata_n;
      end
   end
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign rdata_re  = r_rdata_re;
   assign rdata_im  = r_rdata_im;
   assign mem.req   = r_mem_req;
   assign mem.we    = r_mem_we;
   assign mem.addr  = r_mem_addr;
   assign mem.wdata = r_mem_wdata;
endmodule

// File: tb/tb_complex_mem_port.sv
// tb_complex_mem_port: directed checks of complex_mem_port against a byte memory with configurable wait states.
module tb_complex_mem_port;
   logic clk = 1'b0;
   logic rst, start, we;
   logic [15:0] addr;
   logic [7:0] wdata_re, wdata_im, rdata_re, rdata_im;
   logic busy, done, err;
   int checks = 0, failures = 0;
   int wait_cfg = 0, wcnt = 0;
   logic ack_en = 1'b1;
   logic [7:0] mem_arr [0:65535];
   logic [23:0] wlog [$];
   complex_mem_port_if mif();
   complex_mem_port #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .we(we), .addr(addr),
      .wdata_re(wdata_re), .wdata_im(wdata_im), .busy(busy), .done(done), .err(err),
      .rdata_re(rdata_re), .rdata_im(rdata_im), .mem(mif.master)
   );
   always #5 clk = ~clk;
   // Memory responder: acks after wait_cfg stall cycles, one beat per ack.
   initial begin
      mif.ack = 1'b0;
      mif.rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mif.ack) begin
            mif.ack = 1'b0;
            wcnt = 0;
         end
         if (mif.req && ack_en) begin
            if (wcnt == wait_cfg) begin
               mif.ack = 1'b1;
               if (mif.we) begin
                  mem_arr[mif.addr] = mif.wdata;
                  wlog.push_back({mif.addr, mif.wdata});
               end else mif.rdata = mem_arr[mif.addr];
            end else wcnt++;
         end else wcnt = 0;
      end
   end
   task automatic kick(input logic w, input logic [15:0] a, input logic [7:0] r, input logic [7:0] i);
      @(negedge clk);
      we = w; addr = a; wdata_re = r; wdata_im = i; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata_re = '0; wdata_im = '0;
      @(negedge clk);
      checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
      checks++; if ({mif.req, mif.we, mif.addr, mif.wdata} !== 26'h0) begin failures++; $display("FAIL reset_bus got=%h exp=0", {mif.req, mif.we, mif.addr, mif.wdata}); end
      checks++; if ({rdata_re, rdata_im} !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", {rdata_re, rdata_im}); end
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_load;
      mem_arr[16'h1234] = 8'h05; mem_arr[16'h1235] = 8'hFB; wait_cfg = 0;
      kick(1'b0, 16'h1234, 8'h00, 8'h00);
      checks++; if ({mif.req, mif.we, mif.addr} !== {2'b10, 16'h1234}) begin failures++; $display("FAIL load_c1 got=%h exp=%h", {mif.req, mif.we, mif.addr}, {2'b10, 16'h1234}); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy_c1 got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if ({mif.req, mif.addr} !== {1'b1, 16'h1235}) begin failures++; $display("FAIL load_c2 got=%h exp=%h", {mif.req, mif.addr}, {1'b1, 16'h1235}); end
      @(negedge clk);
      checks++; if ({done, busy, mif.req} !== 3'b110) begin failures++; $display("FAIL load_c3 got=%b exp=110", {done, busy, mif.req}); end
      checks++; if ({rdata_re, rdata_im} !== 16'h05FB) begin failures++; $display("FAIL load_rdata got=%h exp=05fb", {rdata_re, rdata_im}); end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL load_c4 got=%b exp=00", {done, busy}); end
   endtask
   task automatic test_store;
      int done_cyc = -1;
      wlog.delete(); wait_cfg = 2;
      kick(1'b1, 16'h00A0, 8'h7F, 8'h80);
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) begin
            checks++; if ({mif.req, mif.we, mif.addr, mif.wdata} !== {2'b11, 16'h00A0, 8'h7F}) begin failures++; $display("FAIL store_hold got=%h exp=%h", {mif.req, mif.we, mif.addr, mif.wdata}, {2'b11, 16'h00A0, 8'h7F}); end
         end
         if (done && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      checks++; if (done_cyc != 7) begin failures++; $display("FAIL store_done_cycle got=%0d exp=7", done_cyc); end
      checks++; if (wlog.size() != 2) begin failures++; $display("FAIL store_beats got=%0d exp=2", wlog.size()); end
      else begin
         checks++; if (wlog[0] !== 24'h00A07F || wlog[1] !== 24'h00A180) begin failures++; $display("FAIL store_writes got=%h,%h exp=00a07f,00a180", wlog[0], wlog[1]); end
      end
      checks++; if ({rdata_re, rdata_im} !== 16'h05FB) begin failures++; $display("FAIL store_rdata got=%h exp=05fb", {rdata_re, rdata_im}); end
      wait_cfg = 0;
   endtask
   task automatic test_wrap;
      mem_arr[16'hFFFF] = 8'h11; mem_arr[16'h0000] = 8'h22;
      kick(1'b0, 16'hFFFF, 8'h00, 8'h00);
      @(negedge clk);
      checks++; if ({mif.req, mif.addr} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", {mif.req, mif.addr}, {1'b1, 16'h0000}); end
      @(negedge clk);
      checks++; if ({done, rdata_re, rdata_im} !== {1'b1, 16'h1122}) begin failures++; $display("FAIL wrap_rdata got=%h exp=%h", {done, rdata_re, rdata_im}, {1'b1, 16'h1122}); end
      @(negedge clk);
   endtask
   task automatic test_timeout;
      int reqc = 0, errc = 0, donec = 0, err_cyc = -1;
      logic busy5 = 1'b0, busy6 = 1'b1;
      ack_en = 1'b0;
      kick(1'b0, 16'h4000, 8'h00, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         if (mif.req) reqc++;
         if (err) begin errc++; if (err_cyc < 0) err_cyc = c; end
         if (done) donec++;
         if (c == 5) busy5 = busy;
         if (c == 6) busy6 = busy;
         @(negedge clk);
      end
      checks++; if (reqc != 4) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=4", reqc); end
      checks++; if (errc != 1 || err_cyc != 5) begin failures++; $display("FAIL timeout_err got=%0d@%0d exp=1@5", errc, err_cyc); end
      checks++; if (donec != 0) begin failures++; $display("FAIL timeout_done got=%0d exp=0", donec); end
      checks++; if ({busy5, busy6} !== 2'b10) begin failures++; $display("FAIL timeout_busy got=%b exp=10", {busy5, busy6}); end
      checks++; if ({rdata_re, rdata_im} !== 16'h1122) begin failures++; $display("FAIL timeout_rdata got=%h exp=1122", {rdata_re, rdata_im}); end
      ack_en = 1'b1;
   endtask
   task automatic test_back_to_back;
      mem_arr[16'h1000] = 8'hAA; mem_arr[16'h1001] = 8'h55;
      @(negedge clk);
      we = 1'b0; addr = 16'h1234; start = 1'b1;
      @(negedge clk);
      addr = 16'h1000;
      checks++; if ({mif.req, mif.addr} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL b2b_c1 got=%h exp=%h", {mif.req, mif.addr}, {1'b1, 16'h1234}); end
      @(negedge clk);
      checks++; if (mif.addr !== 16'h1235) begin failures++; $display("FAIL b2b_c2 got=%h exp=1235", mif.addr); end
      @(negedge clk);
      checks++; if ({done, rdata_re, rdata_im} !== {1'b1, 16'h05FB}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {done, rdata_re, rdata_im}, {1'b1, 16'h05FB}); end
      @(negedge clk);
      checks++; if ({busy, done, mif.req} !== 3'b000) begin failures++; $display("FAIL b2b_c4 got=%b exp=000", {busy, done, mif.req}); end
      @(negedge clk);
      start = 1'b0;
      checks++; if ({mif.req, mif.addr} !== {1'b1, 16'h1000}) begin failures++; $display("FAIL b2b_second_start got=%h exp=%h", {mif.req, mif.addr}, {1'b1, 16'h1000}); end
      @(negedge clk);
      @(negedge clk);
      checks++; if ({done, rdata_re, rdata_im} !== {1'b1, 16'hAA55}) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {done, rdata_re, rdata_im}, {1'b1, 16'hAA55}); end
      @(negedge clk);
   endtask
   task automatic test_reset_mid;
      wait_cfg = 2;
      kick(1'b0, 16'h1234, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checks++; if ({mif.req, mif.addr} !== {1'b1, 16'h1235}) begin failures++; $display("FAIL rstmid_in_im got=%h exp=%h", {mif.req, mif.addr}, {1'b1, 16'h1235}); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({mif.req, busy, rdata_re, rdata_im} !== 18'h0) begin failures++; $display("FAIL rstmid_async got=%h exp=0", {mif.req, busy, rdata_re, rdata_im}); end
      @(negedge clk);
      checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL rstmid_pulse got=%b exp=00", {done, err}); end
      rst = 1'b0; wait_cfg = 0;
      kick(1'b0, 16'h1234, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      checks++; if ({done, rdata_re, rdata_im} !== {1'b1, 16'h05FB}) begin failures++; $display("FAIL rstmid_after got=%h exp=%h", {done, rdata_re, rdata_im}, {1'b1, 16'h05FB}); end
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end
   initial begin
      test_reset();
      test_load();
      test_store();
      test_wrap();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/complex_mem_port.md
# complex_mem_port

Load/store engine sitting downstream of the complex ALU's memory-access operation. It takes the 16-bit effective address the ALU produces as {Out1, Out2} and moves one complex word (real byte, imaginary byte) between the register file and an 8-bit data memory. The memory is driven over a req/ack handshake as two sequential byte beats. A watchdog aborts the transfer if the memory stalls.

## Interface
- NUMBER_SIZE, 8, width of one real or imaginary component and of a memory byte
- ADDR_SIZE, 16, effective address width; equals 2*NUMBER_SIZE
- TIMEOUT, 255, maximum cycles a beat may wait for mem_ack before abort
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a transfer; sampled only in IDLE
- we  in  1  1 = store, 0 = load; captured with start
- addr  in  ADDR_SIZE  effective address ({Out1,Out2} of ALU); captured with start
- wdata_re, wdata_im  in  NUMBER_SIZE each  store data; captured with start
- busy  out  1  high from the cycle after an accepted start until the cycle after done/err
- done  out  1  one-cycle pulse, transfer completed
- err  out  1  one-cycle pulse, transfer aborted by timeout
- rdata_re, rdata_im  out  NUMBER_SIZE each  load result; updated only when done pulses on a load
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_SIZE  beat address
- mem_wdata  out  NUMBER_SIZE  beat write data
- mem_rdata  in  NUMBER_SIZE  beat read data, valid when mem_ack is high
- mem_ack  in  1  beat accepted/completed

## Operation
- FSM states: IDLE, BEAT_RE, BEAT_IM, FINISH.
- IDLE: start=1 captures we, addr, wdata_re, wdata_im. Next state is BEAT_RE. Counter clears.
- BEAT_RE: mem_req=1, mem_addr=addr, mem_we=we, mem_wdata=wdata_re.
  - mem_ack=1 at the clock edge: on a load, capture mem_rdata into a real holding register; go to BEAT_IM.
- BEAT_IM: same as BEAT_RE with mem_addr=addr+1 and mem_wdata=wdata_im.
  - mem_ack: capture the imaginary byte on a load; go to FINISH.
- FINISH: done=1 for exactly one cycle.
  - On a load, rdata_re/rdata_im take the holding registers in the same edge that enters FINISH.
  - Next state is IDLE.
- Address arithmetic: addr+1 is modulo 2^ADDR_SIZE, so 16'hFFFF wraps to 16'h0000.
- Watchdog: counter increments each cycle mem_req=1 and mem_ack=0, and clears on each ack.
  - When the counter reaches TIMEOUT without an ack: drop mem_req, pulse err for one cycle, return to IDLE.
  - On abort, rdata is unchanged. A store may have written the real byte only; no rollback.
- start while busy is ignored; there is no queue.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1. Outside a beat they are 0.
- rdata_re/rdata_im hold their value across stores, errors and idle periods.

## Timing
- Reset values: busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_re=0, rdata_im=0. State is IDLE and the counter is 0.
- All outputs are registered; none is combinational from inputs.
- Cycle 0: start sampled. Cycle 1: mem_req=1 for BEAT_RE.
- With zero-wait memory (ack in the first req cycle): BEAT_IM in cycle 2, done in cycle 3, busy low in cycle 4. Accepting a new start in cycle 4 is legal.
- Each wait cycle adds one cycle of latency.
- There is no idle cycle between beats. mem_req stays high across BEAT_RE to BEAT_IM; mem_addr changes in the edge that consumed the first ack.
- An ack seen while mem_req=0 is ignored.
- Reset asserted mid-transfer: all outputs return to reset values immediately, without waiting for clk, and no done or err pulse is produced.

## Structure
- The shared package holds:
  - NUMBER_SIZE and ADDR_SIZE
  - the FSM state enum
  - the ALU memory-access opcode constant 4'b1111, so the decoder and this block agree on it
- One natural sub-module, mem_watchdog, holding the TIMEOUT counter with clear/enable/expired ports. Everything else is one FSM module.

## Test plan
- Load, zero-wait memory, addr=16'h1234 with mem[1234]=8'h05 and mem[1235]=8'hFB -> mem_req in cycles 1–2, done in cycle 3, rdata_re=8'h05, rdata_im=8'hFB.
- Store addr=16'h00A0, wdata_re=8'h7F, wdata_im=8'h80, with 2 wait cycles per beat -> two write beats at 00A0 and 00A1, done in cycle 7, rdata unchanged.
- Wrap: load at addr=16'hFFFF -> second beat mem_addr=16'h0000.
- Timeout with TIMEOUT=4 and mem_ack tied low -> mem_req high for 4 cycles, then err pulses for one cycle, busy drops, done never asserts, rdata unchanged.
- start pulsed in every cycle of a transfer -> exactly one transfer executes; the next one starts only after busy falls.
- rst asserted while mem_req=1 in BEAT_IM -> mem_req, busy and rdata go to 0 immediately without waiting for clk. A following start runs a clean full transfer.
